// File: rtl/xmit_pkt_gen.sv
// Packet stimulus generator for the transmit path.
// Emits header / body / trailer bytes with a control block on the first byte,
// supports back-to-back or gapped packets, hold, and graceful stop.
// Outputs are registered one stage behind the FSM; hold freezes both the FSM
// and the output stage so the pending byte is presented again on release.
module xmit_pkt_gen #(
    parameter int unsigned         DATA_W  = 8,
    parameter int unsigned         LEN_W   = 12,
    parameter int unsigned         CNT_W   = 16,
    parameter int unsigned         PAD_LEN = 4,
    parameter logic [DATA_W-1:0]   FILL    = 8'hFF
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 gen_hold,
    input  logic [LEN_W-1:0]     cfg_len,
    input  logic [CNT_W-1:0]     cfg_num_pkts,
    input  logic [7:0]           cfg_gap,
    input  logic                 cfg_mode,
    input  logic                 cfg_hi_priority,
    output logic [DATA_W-1:0]    gen_data,
    output logic                 gen_data_valid,
    output logic [2*LEN_W-1:0]   gen_ctrl,
    output logic                 gen_ctrl_valid,
    output logic                 gen_hi_priority,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     pkt_count
);

    typedef enum logic [2:0] {
        StIdle,
        StHead,
        StBody,
        StTail,
        StGap,
        StDone
    } state_t;

    localparam logic [LEN_W-1:0] MinLen  = LEN_W'(2 * PAD_LEN);
    localparam logic [LEN_W-1:0] PadLast = LEN_W'(PAD_LEN - 1);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   body_q;
    logic [CNT_W-1:0]   num_q;
    logic [7:0]         gap_cfg_q;
    logic               mode_q;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [7:0]         gap_q, gap_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               stop_pend_q, stop_pend_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               dvalid_q, dvalid_d;
    logic               cvalid_q, cvalid_d;
    logic               prio_q;
    logic               busy_q, busy_d;
    logic               done_q;
    logic               latch_cfg;
    logic               sample_prio;
    logic               freeze;
    logic               run_last;
    logic               stop_now;
    logic [LEN_W-1:0]   eff_len;

    // Hold freezes everything except the idle state, so a start is never lost.
    assign freeze   = gen_hold && (state_q != StIdle);
    assign eff_len  = (cfg_len < MinLen) ? MinLen : cfg_len;
    assign run_last = (num_q != '0) && ((cnt_q + 1'b1) == num_q);
    assign stop_now = stop_pend_q | stop;

    // Next-state, byte generation and counter updates.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        cnt_d       = cnt_q;
        data_d      = '0;
        dvalid_d    = 1'b0;
        cvalid_d    = 1'b0;
        latch_cfg   = 1'b0;
        sample_prio = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StHead;
                    idx_d     = '0;
                    cnt_d     = '0;
                    latch_cfg = 1'b1;
                end
            end
            StHead: begin
                dvalid_d    = 1'b1;
                cvalid_d    = (idx_q == '0);
                sample_prio = (idx_q == '0);
                if (idx_q == PadLast) begin
                    idx_d   = '0;
                    state_d = (body_q == '0) ? StTail : StBody;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StBody: begin
                dvalid_d = 1'b1;
                data_d   = mode_q ? DATA_W'(idx_q) : FILL;
                if (idx_q == body_q - 1'b1) begin
                    idx_d   = '0;
                    state_d = StTail;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StTail: begin
                dvalid_d = 1'b1;
                if (idx_q == PadLast) begin
                    idx_d = '0;
                    cnt_d = cnt_q + 1'b1;
                    if (run_last || stop_now) begin
                        state_d = StDone;
                    end else if (gap_cfg_q != 8'd0) begin
                        state_d = StGap;
                        gap_d   = 8'd0;
                    end else begin
                        state_d = StHead;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StGap: begin
                if (stop_now) begin
                    state_d = StDone;
                end else if (gap_q == gap_cfg_q - 8'd1) begin
                    state_d = StHead;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Sticky stop request; start+stop together yields a single-packet run.
    always_comb begin
        stop_pend_d = stop_pend_q | stop;
        if (state_q == StIdle) begin
            stop_pend_d = start & stop;
        end else if (state_q == StDone && !freeze) begin
            stop_pend_d = 1'b0;
        end
    end

    // busy stays high through the done cycle and drops the cycle after.
    assign busy_d = (state_d != StIdle) || (state_q == StDone);

    // State, counters and output stage; all frozen while hold is applied.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            len_q       <= '0;
            body_q      <= '0;
            num_q       <= '0;
            gap_cfg_q   <= '0;
            mode_q      <= 1'b0;
            idx_q       <= '0;
            gap_q       <= '0;
            cnt_q       <= '0;
            stop_pend_q <= 1'b0;
            data_q      <= '0;
            dvalid_q    <= 1'b0;
            cvalid_q    <= 1'b0;
            prio_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            stop_pend_q <= stop_pend_d;
            done_q      <= (state_q == StDone) && !freeze;
            if (!freeze) begin
                state_q  <= state_d;
                idx_q    <= idx_d;
                gap_q    <= gap_d;
                cnt_q    <= cnt_d;
                data_q   <= data_d;
                dvalid_q <= dvalid_d;
                cvalid_q <= cvalid_d;
                busy_q   <= busy_d;
                if (sample_prio) begin
                    prio_q <= cfg_hi_priority;
                end
                if (latch_cfg) begin
                    len_q     <= eff_len;
                    body_q    <= eff_len - MinLen;
                    num_q     <= cfg_num_pkts;
                    gap_cfg_q <= cfg_gap;
                    mode_q    <= cfg_mode;
                end
            end
        end
    end

    assign gen_data        = data_q;
    assign gen_data_valid  = dvalid_q & ~gen_hold;
    assign gen_ctrl_valid  = cvalid_q & ~gen_hold;
    assign gen_ctrl        = gen_ctrl_valid ? {len_q, len_q} : '0;
    assign gen_hi_priority = prio_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pkt_count       = cnt_q;

endmodule

// File: doc/xmit_pkt_gen.md
Name: xmit_pkt_gen

Overview:
Parametrised, synthesizable packet stimulus generator for the transmit path. It drives xmitTop's receive-side interface: data byte, data valid, control block, control-block valid and high-priority flag. Packet length, packet count, inter-packet gap, fill mode and priority are set at run time. It replaces hand-written fixed-timing stimulus and supports back-to-back traffic, gaps, hold and graceful stop.

Parameters:
DATA_W, 8, data byte width
LEN_W, 12, packet length field width; max packet length 2^LEN_W-1
CNT_W, 16, packet count / counter width
PAD_LEN, 4, header and trailer byte count, each driven as all-zero
FILL, 8'hFF, body byte in fixed mode

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a run from IDLE
stop  in  1  request graceful stop after the current packet
gen_hold  in  1  freeze generation; no valid output while high
cfg_len  in  LEN_W  packet length in bytes
cfg_num_pkts  in  CNT_W  packets per run; 0 = continuous
cfg_gap  in  8  idle cycles between packets
cfg_mode  in  1  0 = fixed FILL body; 1 = incrementing body
cfg_hi_priority  in  1  priority for the next packet
gen_data  out  DATA_W  data byte
gen_data_valid  out  1  data byte valid
gen_ctrl  out  2*LEN_W  control block: [2*LEN_W-1:LEN_W] = length, [LEN_W-1:0] = length
gen_ctrl_valid  out  1  control block valid, first byte of each packet only
gen_hi_priority  out  1  priority of the current packet
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse at end of run
pkt_count  out  CNT_W  completed packets in the current run

Behaviour:
- Reset, asynchronous: every output is 0; FSM goes to IDLE; counters are cleared. Reset mid-packet truncates the packet immediately, with no trailer.
- FSM states: IDLE, HEAD, BODY, TAIL, GAP, DONE.
- IDLE: when start=1, the block latches cfg_len, cfg_num_pkts, cfg_gap and cfg_mode, clears pkt_count, and goes to HEAD. busy rises the next cycle. start is ignored outside IDLE.
- Effective length L = max(cfg_len, 2*PAD_LEN). Body length = L - 2*PAD_LEN; if 0, BODY is skipped.
- Packet timing: the first byte appears on the cycle after entry to HEAD. gen_ctrl_valid=1 with gen_ctrl={L,L} on the first byte only; gen_ctrl=0 otherwise.
- cfg_hi_priority is sampled at each packet's first byte and held on gen_hi_priority through the last byte.
- Data content: HEAD drives PAD_LEN bytes of 0x00. BODY drives FILL (mode 0) or the body index modulo 2^DATA_W starting at 0 (mode 1). TAIL drives PAD_LEN bytes of 0x00. gen_data_valid=1 for exactly L cycles per packet when no hold is applied.
- End of packet: after the last TAIL byte, pkt_count increments.
  - If the run is finished or a stop is pending, go to DONE.
  - Else if cfg_gap>0, go to GAP for cfg_gap cycles with valid=0 and gen_data=0.
  - Else go straight to HEAD; the next packet's first byte immediately follows the last byte (back-to-back).
- Run finished means pkt_count reaches cfg_num_pkts with cfg_num_pkts≠0. With cfg_num_pkts=0 the run only ends via stop.
- stop: a pulse in any non-IDLE state sets a sticky stop-pending flag, cleared on entering IDLE. stop in GAP ends the gap at once and goes to DONE. stop in IDLE is ignored.
- gen_hold=1: on the same cycle, gen_data_valid and gen_ctrl_valid are forced to 0. The FSM, byte and gap counters freeze. On release, the byte that was pending is presented again, including ctrl_valid if it was the first byte.
- DONE: done=1 for one cycle, busy=0 the following cycle, then IDLE. pkt_count holds until the next start.
- pkt_count wraps at 2^CNT_W.
- Simultaneous events:
  - reset dominates everything.
  - hold overrides stop; stop is still registered as pending.
  - start and stop together in IDLE: start the run with stop pending, so exactly one packet is sent.

Test Plan:
1. cfg_len=64, num=64, gap=0, mode=0, hi=1, start -> 64 back-to-back packets; each is 4x00, 56xFF, 4x00. ctrl=0x040040 on bytes 0, 64, 128…; gen_hi_priority=1 throughout. done after byte 4095; pkt_count=64.
2. cfg_len=10, num=3, gap=5, mode=1 -> per packet: 4x00, 0x00, 0x01, 4x00, then 5 idle cycles; valid count = 30; no gap after the 3rd packet; done pulses once.
3. cfg_len=3 (below minimum), num=1 -> clamped to L=8: 8 bytes of 0x00, ctrl=0x008008, body skipped.
4. num=0 (continuous), len=16; stop pulsed during packet 5 body -> packet 5 completes fully, done follows, pkt_count=5. Start pulsed while busy -> no effect.
5. gen_hold high 3 cycles on the first byte of packet 2 -> valid and ctrl_valid low for 3 cycles, then ctrl_valid with byte 0; the packet still has exactly L valid bytes.
6. reset_n low mid-body -> all outputs 0 asynchronously; after release, IDLE with busy=0 and pkt_count=0; a new start produces a correct first packet.
